dsi_line_scheduler: RTL and testbench
=====================================

# dsi_line_scheduler

Sequences SPI-received pixel lines into DSI long-packet transmissions. Sits between the SPI byte receiver and the DSI packet engine. Parses the command byte of each chip-select transaction and steers payload bytes into the line FIFO. When a full line is buffered, it issues one DCS memory-write packet request and tracks line position within the frame.

## Interface
Parameters:
- LINE_BYTES, 480, payload bytes per line
- FRAME_LINES, 240, lines per frame
- CMD_FRAME_START, 8'h3F, SPI command: first line of frame
- CMD_LINE, 8'h6B, SPI command: subsequent line
- DCS_START, 8'h2C, DCS write_memory_start
- DCS_CONT, 8'h3C, DCS write_memory_continue

Ports:
- clock  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- rx_byte_i  in  8  byte from SPI receiver, already in the clock domain
- rx_valid_i  in  1  one-cycle strobe, rx_byte_i valid
- cs_active_i  in  1  SPI chip select asserted, synchronized level
- fifo_wr_o  out  1  line FIFO write strobe
- fifo_wdata_o  out  8  line FIFO write data
- fifo_flush_o  out  1  one-cycle pulse, discard FIFO contents
- tx_ready_i  in  1  DSI engine idle and able to accept a packet
- pkt_start_o  out  1  one-cycle packet request
- pkt_dcs_o  out  8  DCS command for the request; held until pkt_done_i
- pkt_wc_o  out  16  word count, constant LINE_BYTES+1
- pkt_done_i  in  1  one-cycle pulse, packet fully transmitted
- line_count_o  out  8  lines sent in the current frame
- frame_active_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle pulse after the last line of a frame
- err_cmd_o, err_short_o, err_overflow_o  out  1 each  one-cycle error pulses

## Operation
States: IDLE, CMD, PAYLOAD, PAD, QUEUE, SEND, DISCARD.
- armed flag: set whenever cs_active_i is low, cleared on entry to CMD. A new transaction is accepted only after cs has been seen low.
- IDLE: go to CMD when cs_active_i=1 and armed=1.
- CMD: on the first rx_valid_i:
  - CMD_FRAME_START: line_count←0, frame_active←1, dcs←DCS_START, go to PAYLOAD. A restart mid-frame is a legal resync and raises no error.
  - CMD_LINE with frame_active=1: dcs←DCS_CONT, go to PAYLOAD.
  - Anything else, including CMD_LINE with frame_active=0: err_cmd pulse, go to DISCARD.
  - cs drops before any byte: go to IDLE silently.
- PAYLOAD: each rx_valid_i writes the byte to the FIFO and increments byte_cnt (10-bit). On the LINE_BYTES-th byte, go to QUEUE.
- Short line (cs_active_i low in PAYLOAD, byte_cnt<LINE_BYTES, including 0): err_short pulse, then behaviour depends on LINE_PAD_EN (see Configuration).
- QUEUE: when tx_ready_i=1, pulse pkt_start_o and go to SEND.
- SEND: on pkt_done_i, line_count++.
  - If the new count equals FRAME_LINES: frame_active←0, pulse frame_done_o.
  - Then go to IDLE.
- DISCARD: ignore bytes and go to IDLE when cs_active_i=0.
- Any rx_valid_i arriving in QUEUE or SEND is dropped and pulses err_overflow_o, one pulse per byte.
- pkt_done_i outside SEND is ignored.

## Timing
- All outputs registered. Reset value of every output is 0; state←IDLE, byte_cnt←0, armed←0. Reset overrides everything in the same edge, including mid-packet; no flush pulse is issued, since the FIFO shares the reset.
- fifo_wr_o/fifo_wdata_o: 1 cycle after the accepted rx_valid_i.
- Last payload byte strobed at cycle N → QUEUE at N+1 → pkt_start_o at N+2 if tx_ready_i is high. pkt_start_o is otherwise deferred indefinitely.
- cs drop detected at cycle N in PAYLOAD → err_short_o at N+1. fifo_flush_o (non-pad build) also at N+1.
- line_count_o and frame_done_o update 1 cycle after pkt_done_i.
- Simultaneous rx_valid_i and cs drop in PAYLOAD: the byte is written first, then the short-line check uses the updated count. If that byte completes the line, no error.

## Configuration
- LINE_PAD_EN defined: a short line enters PAD, which writes 8'h00 once per cycle until byte_cnt=LINE_BYTES. It then goes to QUEUE and the line is sent and counted normally.
- LINE_PAD_EN undefined: a short line pulses fifo_flush_o and returns to IDLE. It is not sent and not counted; frame_active is unchanged.

## Test plan
- 0x3F + 480 bytes 0x00..0xDF repeating mod 256 → 480 fifo_wr with matching data, one pkt_start with dcs 0x2C and wc 481; after pkt_done, line_count=1.
- Fresh reset, cs low then high, 0x6B + 10 bytes → err_cmd pulse, zero fifo_wr, no pkt_start.
- Line 0x6B + 30 bytes, cs drops → err_short.
  - Without macro: fifo_flush pulse, line_count unchanged.
  - With LINE_PAD_EN: 450 zero writes, then pkt_start with dcs 0x3C.
- 0x3F line + 239 full 0x6B lines → 240 packets, frame_done pulse after the 240th pkt_done, frame_active=0. A following 0x6B → err_cmd.
- tx_ready_i held low 100 cycles after a full line, 5 extra bytes sent → pkt_start waits for tx_ready, 5 err_overflow pulses.
- reset asserted after 100 PAYLOAD bytes → all outputs 0 the next cycle. A subsequent cs cycle with 0x3F + 480 bytes is sent normally.

Source files
------------

// File: rtl/dsi_line_scheduler_if.sv
// dsi_line_scheduler_if: SPI byte, line FIFO, DSI packet and status signals of the line scheduler
interface dsi_line_scheduler_if;
  logic [7:0] rx_byte_i;
  logic rx_valid_i;
  logic cs_active_i;
  logic fifo_wr_o;
  logic [7:0] fifo_wdata_o;
  logic fifo_flush_o;
  logic tx_ready_i;
  logic pkt_start_o;
  logic [7:0] pkt_dcs_o;
  logic [15:0] pkt_wc_o;
  logic pkt_done_i;
  logic [7:0] line_count_o;
  logic frame_active_o;
  logic frame_done_o;
  logic err_cmd_o;
  logic err_short_o;
  logic err_overflow_o;
  modport master (
    output rx_byte_i, rx_valid_i, cs_active_i, tx_ready_i, pkt_done_i,
    input fifo_wr_o, fifo_wdata_o, fifo_flush_o, pkt_start_o, pkt_dcs_o, pkt_wc_o,
    input line_count_o, frame_active_o, frame_done_o, err_cmd_o, err_short_o, err_overflow_o
  );
  modport slave (
    input rx_byte_i, rx_valid_i, cs_active_i, tx_ready_i, pkt_done_i,
    output fifo_wr_o, fifo_wdata_o, fifo_flush_o, pkt_start_o, pkt_dcs_o, pkt_wc_o,
    output line_count_o, frame_active_o, frame_done_o, err_cmd_o, err_short_o, err_overflow_o
  );
endinterface

// File: rtl/dsi_line_scheduler.sv
// dsi_line_scheduler: steers SPI pixel lines into the line FIFO and requests one DCS write packet per line; define LINE_PAD_EN to zero-pad short lines instead of flushing them
module dsi_line_scheduler #(
  parameter int LINE_BYTES = 480,
  parameter int FRAME_LINES = 240,
  parameter logic [7:0] CMD_FRAME_START = 8'h3F,
  parameter logic [7:0] CMD_LINE = 8'h6B,
  parameter logic [7:0] DCS_START = 8'h2C,
  parameter logic [7:0] DCS_CONT = 8'h3C
) (
  input logic clock,
  input logic reset,
  dsi_line_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, PAD, QUEUE, SEND, DISCARD} state_t;
  state_t state_q, state_d;
  logic armed_q, armed_d, frame_active_q, frame_active_d;
  logic [9:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] line_cnt_q, line_cnt_d, dcs_q, dcs_d, pkt_dcs_q, pkt_dcs_d, fifo_wdata_q, fifo_wdata_d;
  logic [15:0] pkt_wc_q, pkt_wc_d;
  logic fifo_wr_q, fifo_wr_d, fifo_flush_q, fifo_flush_d, pkt_start_q, pkt_start_d;
  logic frame_done_q, frame_done_d, err_cmd_q, err_cmd_d, err_short_q, err_short_d, err_ovf_q, err_ovf_d;
  // next-state and registered-output computation; pulses default low, state defaults to hold
  always_comb begin
    state_d = state_q;
    armed_d = bus.cs_active_i ? armed_q : 1'b1;
    frame_active_d = frame_active_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    dcs_d = dcs_q;
    pkt_dcs_d = pkt_dcs_q;
    pkt_wc_d = pkt_wc_q;
    fifo_wdata_d = fifo_wdata_q;
    fifo_wr_d = 1'b0;
    fifo_flush_d = 1'b0;
    pkt_start_d = 1'b0;
    frame_done_d = 1'b0;
    err_cmd_d = 1'b0;
    err_short_d = 1'b0;
    err_ovf_d = 1'b0;
    case (state_q)
      IDLE: if (bus.cs_active_i && armed_q) begin
        state_d = CMD;
        armed_d = 1'b0;
      end
      CMD: if (bus.rx_valid_i) begin
        if (bus.rx_byte_i == CMD_FRAME_START) begin
          line_cnt_d = '0;
          frame_active_d = 1'b1;
          dcs_d = DCS_START;
          byte_cnt_d = '0;
          state_d = PAYLOAD;
        end else if (bus.rx_byte_i == CMD_LINE && frame_active_q) begin
          dcs_d = DCS_CONT;
          byte_cnt_d = '0;
          state_d = PAYLOAD;
        end else begin
          err_cmd_d = 1'b1;
          state_d = DISCARD;
        end
      end else if (!bus.cs_active_i) state_d = IDLE;
      PAYLOAD: begin
        byte_cnt_d = byte_cnt_q + 10'(bus.rx_valid_i);
        fifo_wr_d = bus.rx_valid_i;
        fifo_wdata_d = bus.rx_valid_i ? bus.rx_byte_i : fifo_wdata_q;
        if (byte_cnt_d == 10'(LINE_BYTES)) state_d = QUEUE;
        else if (!bus.cs_active_i) begin
          err_short_d = 1'b1;
`ifdef LINE_PAD_EN
          state_d = PAD;
`else
          fifo_flush_d = 1'b1;
          state_d = IDLE;
`endif
        end
      end
      PAD: begin
        byte_cnt_d = byte_cnt_q + 10'd1;
        fifo_wr_d = 1'b1;
        fifo_wdata_d = 8'h00;
        if (byte_cnt_d == 10'(LINE_BYTES)) state_d = QUEUE;
      end
      QUEUE: begin
        err_ovf_d = bus.rx_valid_i;
        if (bus.tx_ready_i) begin
          pkt_start_d = 1'b1;
          pkt_dcs_d = dcs_q;
          pkt_wc_d = 16'(LINE_BYTES + 1);
          state_d = SEND;
        end
      end
      SEND: begin
        err_ovf_d = bus.rx_valid_i;
        if (bus.pkt_done_i) begin
          line_cnt_d = line_cnt_q + 8'd1;
          frame_done_d = line_cnt_d == 8'(FRAME_LINES);
          frame_active_d = frame_active_q && !frame_done_d;
          state_d = IDLE;
        end
      end
      DISCARD: if (!bus.cs_active_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      frame_active_q <= 1'b0;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      dcs_q <= '0;
      pkt_dcs_q <= '0;
      pkt_wc_q <= '0;
      fifo_wdata_q <= '0;
      fifo_wr_q <= 1'b0;
      fifo_flush_q <= 1'b0;
      pkt_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_cmd_q <= 1'b0;
      err_short_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      frame_active_q <= frame_active_d;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      dcs_q <= dcs_d;
      pkt_dcs_q <= pkt_dcs_d;
      pkt_wc_q <= pkt_wc_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_wr_q <= fifo_wr_d;
      fifo_flush_q <= fifo_flush_d;
      pkt_start_q <= pkt_start_d;
      frame_done_q <= frame_done_d;
      err_cmd_q <= err_cmd_d;
      err_short_q <= err_short_d;
      err_ovf_q <= err_ovf_d;
    end
  end
  assign bus.fifo_wr_o = fifo_wr_q;
  assign bus.fifo_wdata_o = fifo_wdata_q;
  assign bus.fifo_flush_o = fifo_flush_q;
  assign bus.pkt_start_o = pkt_start_q;
  assign bus.pkt_dcs_o = pkt_dcs_q;
  assign bus.pkt_wc_o = pkt_wc_q;
  assign bus.line_count_o = line_cnt_q;
  assign bus.frame_active_o = frame_active_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.err_cmd_o = err_cmd_q;
  assign bus.err_short_o = err_short_q;
  assign bus.err_overflow_o = err_ovf_q;
endmodule

// File: tb/tb_dsi_line_scheduler.sv
// tb_dsi_line_scheduler: scoreboard bench for the SPI-to-DSI line scheduler
module tb_dsi_line_scheduler;
  localparam int LB = 64;
  localparam int FL = 240;
  localparam logic [7:0] C_FS = 8'h3F, C_LN = 8'h6B, D_ST = 8'h2C, D_CT = 8'h3C;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  dsi_line_scheduler_if bus();
  dsi_line_scheduler #(.LINE_BYTES(LB), .FRAME_LINES(FL)) dut (.clock(clock), .reset(reset), .bus(bus));
  int n_checks = 0, n_fail = 0;
  int n_wr = 0, n_pkt = 0, n_flush = 0, n_ecmd = 0, n_eshort = 0, n_eovf = 0, n_fdone = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt_q[$];
  logic [7:0] exp_b, exp_d;
  // output monitor: pops the scoreboard on every FIFO write and packet request
  always @(negedge clock) begin
    if (bus.fifo_wr_o === 1'b1) begin
      n_wr++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_unexpected: write of 0x%02h, required no write", bus.fifo_wdata_o);
      end else begin
        exp_b = exp_q.pop_front();
        if (bus.fifo_wdata_o !== exp_b) begin
          n_fail++;
          $display("FAIL fifo_data: got 0x%02h, required 0x%02h", bus.fifo_wdata_o, exp_b);
        end
      end
    end
    if (bus.pkt_start_o === 1'b1) begin
      n_pkt++;
      n_checks++;
      if (pkt_q.size() == 0) begin
        n_fail++;
        $display("FAIL pkt_unexpected: dcs 0x%02h, required no packet", bus.pkt_dcs_o);
      end else begin
        exp_d = pkt_q.pop_front();
        if (bus.pkt_dcs_o !== exp_d || bus.pkt_wc_o !== 16'(LB + 1)) begin
          n_fail++;
          $display("FAIL pkt_fields: got dcs 0x%02h wc %0d, required dcs 0x%02h wc %0d", bus.pkt_dcs_o, bus.pkt_wc_o, exp_d, LB + 1);
        end
      end
    end
    if (bus.fifo_flush_o === 1'b1) n_flush++;
    if (bus.err_cmd_o === 1'b1) n_ecmd++;
    if (bus.err_short_o === 1'b1) n_eshort++;
    if (bus.err_overflow_o === 1'b1) n_eovf++;
    if (bus.frame_done_o === 1'b1) n_fdone++;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [47:0] outs();
    return {bus.fifo_wr_o, bus.fifo_wdata_o, bus.fifo_flush_o, bus.pkt_start_o, bus.pkt_dcs_o, bus.pkt_wc_o,
            bus.line_count_o, bus.frame_active_o, bus.frame_done_o, bus.err_cmd_o, bus.err_short_o, bus.err_overflow_o};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_byte_i = 8'h00;
    bus.cs_active_i = 1'b0;
    bus.tx_ready_i = 1'b0;
    bus.pkt_done_i = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    pkt_q.delete();
    reset = 1'b0;
    tick();
  endtask
  task automatic put_byte(input logic [7:0] b);
    bus.rx_byte_i = b;
    bus.rx_valid_i = 1'b1;
    tick();
    bus.rx_valid_i = 1'b0;
  endtask
  task automatic cs_cycle();
    bus.cs_active_i = 1'b0;
    repeat (2) tick();
    bus.cs_active_i = 1'b1;
    tick();
  endtask
  task automatic send_line(input logic [7:0] cmd, input int n, input int seed, input bit ok);
    cs_cycle();
    put_byte(cmd);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'(seed + i);
      if (ok) exp_q.push_back(b);
      put_byte(b);
    end
  endtask
  task automatic complete_pkt();
    for (int k = 0; k < 300 && bus.pkt_start_o !== 1'b1; k++) tick();
    n_checks++;
    if (bus.pkt_start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pkt_timeout: pkt_start_o %b, required 1 within 300 cycles", bus.pkt_start_o);
    end
    bus.pkt_done_i = 1'b1;
    tick();
    bus.pkt_done_i = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (outs() !== 48'h0) begin n_fail++; $display("FAIL reset_outputs: got 0x%012h, required 0", outs()); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.cs_active_i = 1'b1;
    tick();
    put_byte(C_FS);
    repeat (3) put_byte(8'h11);
    bus.pkt_done_i = 1'b1;
    tick();
    bus.pkt_done_i = 1'b0;
    tick();
    n_checks++;
    if (outs() !== 48'h0 || n_wr !== 0) begin n_fail++; $display("FAIL unarmed_ignored: outputs 0x%012h writes %0d, required 0 and 0", outs(), n_wr); end
  endtask
  task automatic test_full_line();
    int w0, p0;
    do_reset();
    bus.tx_ready_i = 1'b1;
    w0 = n_wr;
    p0 = n_pkt;
    pkt_q.push_back(D_ST);
    send_line(C_FS, LB, 0, 1'b1);
    n_checks++;
    if (bus.pkt_start_o !== 1'b0) begin n_fail++; $display("FAIL pkt_early: pkt_start_o %b, required 0", bus.pkt_start_o); end
    tick();
    n_checks++;
    if (bus.pkt_start_o !== 1'b1 || bus.pkt_dcs_o !== D_ST || bus.pkt_wc_o !== 16'(LB + 1)) begin
      n_fail++;
      $display("FAIL pkt_latency: start %b dcs 0x%02h wc %0d, required 1 0x%02h %0d", bus.pkt_start_o, bus.pkt_dcs_o, bus.pkt_wc_o, D_ST, LB + 1);
    end
    complete_pkt();
    n_checks++;
    if (bus.line_count_o !== 8'd1 || bus.frame_active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL line_count_first: count %0d active %b, required 1 1", bus.line_count_o, bus.frame_active_o);
    end
    tick();
    n_checks++;
    if (n_wr - w0 !== LB || n_pkt - p0 !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL full_line_totals: writes %0d pkts %0d left %0d, required %0d 1 0", n_wr - w0, n_pkt - p0, exp_q.size(), LB);
    end
  endtask
  task automatic test_bad_cmd();
    int w0, p0, e0;
    do_reset();
    bus.tx_ready_i = 1'b1;
    w0 = n_wr;
    p0 = n_pkt;
    e0 = n_ecmd;
    send_line(C_LN, 10, 8'h20, 1'b0);
    bus.cs_active_i = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (n_ecmd - e0 !== 1 || n_wr !== w0 || n_pkt !== p0) begin
      n_fail++;
      $display("FAIL bad_cmd: err_cmd %0d writes %0d pkts %0d, required 1 0 0", n_ecmd - e0, n_wr - w0, n_pkt - p0);
    end
  endtask
  task automatic test_short_line();
    int p0, s0, f0;
    do_reset();
    bus.tx_ready_i = 1'b1;
    pkt_q.push_back(D_ST);
    send_line(C_FS, LB, 8'h40, 1'b1);
    complete_pkt();
    p0 = n_pkt;
    s0 = n_eshort;
    f0 = n_flush;
    send_line(C_LN, 30, 8'h80, 1'b1);
`ifdef LINE_PAD_EN
    for (int i = 30; i < LB; i++) exp_q.push_back(8'h00);
    pkt_q.push_back(D_CT);
`endif
    bus.cs_active_i = 1'b0;
    tick();
    n_checks++;
    if (bus.err_short_o !== 1'b1) begin n_fail++; $display("FAIL short_pulse: err_short_o %b, required 1", bus.err_short_o); end
`ifdef LINE_PAD_EN
    complete_pkt();
    n_checks++;
    if (bus.line_count_o !== 8'd2 || n_pkt - p0 !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL short_pad: count %0d pkts %0d left %0d, required 2 1 0", bus.line_count_o, n_pkt - p0, exp_q.size());
    end
`else
    n_checks++;
    if (bus.fifo_flush_o !== 1'b1) begin n_fail++; $display("FAIL short_flush: fifo_flush_o %b, required 1", bus.fifo_flush_o); end
    repeat (20) tick();
    n_checks++;
    if (bus.line_count_o !== 8'd1 || bus.frame_active_o !== 1'b1 || n_pkt !== p0 || n_flush - f0 !== 1 || n_eshort - s0 !== 1) begin
      n_fail++;
      $display("FAIL short_drop: count %0d active %b pkts %0d flush %0d short %0d, required 1 1 0 1 1",
               bus.line_count_o, bus.frame_active_o, n_pkt - p0, n_flush - f0, n_eshort - s0);
    end
`endif
  endtask
  task automatic test_last_byte_drop();
    int s0;
    do_reset();
    bus.tx_ready_i = 1'b1;
    s0 = n_eshort;
    pkt_q.push_back(D_ST);
    send_line(C_FS, LB - 1, 8'hC0, 1'b1);
    bus.cs_active_i = 1'b0;
    exp_q.push_back(8'h5A);
    put_byte(8'h5A);
    tick();
    n_checks++;
    if (bus.pkt_start_o !== 1'b1 || n_eshort !== s0) begin
      n_fail++;
      $display("FAIL last_byte_drop: pkt_start %b short %0d, required 1 0", bus.pkt_start_o, n_eshort - s0);
    end
    complete_pkt();
  endtask
  task automatic test_back_to_back();
    int p0, e0;
    do_reset();
    bus.tx_ready_i = 1'b1;
    p0 = n_pkt;
    for (int l = 0; l < FL; l++) begin
      pkt_q.push_back(l == 0 ? D_ST : D_CT);
      send_line(l == 0 ? C_FS : C_LN, LB, l * 7, 1'b1);
      if (l == FL - 1) begin
        n_checks++;
        if (n_fdone !== 0 || bus.frame_active_o !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_early: frame_done %0d active %b, required 0 1", n_fdone, bus.frame_active_o);
        end
      end
      complete_pkt();
    end
    n_checks++;
    if (bus.frame_done_o !== 1'b1 || bus.frame_active_o !== 1'b0 || bus.line_count_o !== 8'(FL)) begin
      n_fail++;
      $display("FAIL frame_end: done %b active %b count %0d, required 1 0 %0d", bus.frame_done_o, bus.frame_active_o, bus.line_count_o, FL);
    end
    tick();
    n_checks++;
    if (bus.frame_done_o !== 1'b0 || n_fdone !== 1 || n_pkt - p0 !== FL) begin
      n_fail++;
      $display("FAIL frame_totals: done %b pulses %0d pkts %0d, required 0 1 %0d", bus.frame_done_o, n_fdone, n_pkt - p0, FL);
    end
    e0 = n_ecmd;
    send_line(C_LN, 4, 0, 1'b0);
    bus.cs_active_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (n_ecmd - e0 !== 1) begin n_fail++; $display("FAIL line_after_frame: err_cmd %0d, required 1", n_ecmd - e0); end
  endtask
  task automatic test_backpressure();
    int p0, o0;
    do_reset();
    p0 = n_pkt;
    o0 = n_eovf;
    pkt_q.push_back(D_ST);
    send_line(C_FS, LB, 8'h55, 1'b1);
    repeat (5) put_byte(8'hEE);
    repeat (95) tick();
    n_checks++;
    if (n_pkt !== p0 || n_eovf - o0 !== 5) begin
      n_fail++;
      $display("FAIL backpressure_hold: pkts %0d overflow %0d, required 0 5", n_pkt - p0, n_eovf - o0);
    end
    bus.tx_ready_i = 1'b1;
    tick();
    n_checks++;
    if (bus.pkt_start_o !== 1'b1) begin n_fail++; $display("FAIL backpressure_release: pkt_start_o %b, required 1", bus.pkt_start_o); end
    complete_pkt();
    n_checks++;
    if (bus.line_count_o !== 8'd1) begin n_fail++; $display("FAIL backpressure_count: count %0d, required 1", bus.line_count_o); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.tx_ready_i = 1'b1;
    send_line(C_FS, LB - 10, 8'h10, 1'b1);
    reset = 1'b1;
    tick();
    n_checks++;
    if (outs() !== 48'h0) begin n_fail++; $display("FAIL reset_mid: outputs 0x%012h, required 0", outs()); end
    reset = 1'b0;
    tick();
    pkt_q.push_back(D_ST);
    send_line(C_FS, LB, 8'h99, 1'b1);
    complete_pkt();
    n_checks++;
    if (bus.line_count_o !== 8'd1 || bus.frame_active_o !== 1'b1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_recover: count %0d active %b left %0d, required 1 1 0", bus.line_count_o, bus.frame_active_o, exp_q.size());
    end
  endtask
  initial begin
    test_reset();
    test_full_line();
    test_bad_cmd();
    test_short_line();
    test_last_byte_drop();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
